// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard/sequencing controller.
// The datapath (master) drives hazard sources and memory status; the controller (slave) drives stage-register controls.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       src1;
    logic [3:0]       src2;
    logic             src1_used;
    logic             src2_used;
    logic [3:0]       exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_r_en;
    logic [3:0]       mem_dest;
    logic             mem_wb_en;
    logic             fwd_en;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             freeze_front;
    logic             freeze_back;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             hazard;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output src1, src2, src1_used, src2_used, exe_dest, exe_wb_en, exe_mem_r_en,
               mem_dest, mem_wb_en, fwd_en, branch_taken, mem_req, mem_ready,
        input  freeze_front, freeze_back, flush_if_id, flush_id_ex, hazard, mem_err,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  src1, src2, src1_used, src2_used, exe_dest, exe_wb_en, exe_mem_r_en,
               mem_dest, mem_wb_en, fwd_en, branch_taken, mem_req, mem_ready,
        output freeze_front, freeze_back, flush_if_id, flush_id_ex, hazard, mem_err,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Freeze/flush sequencing for the 5-stage pipeline registers: memory wait, branch flush, data hazards.
// state    | meaning
// RUN      | normal issue; branch and data hazards evaluated here
// MEM_WAIT | memory access outstanding, whole pipe frozen, timeout counting
// BR_FLUSH | extra bubble cycles after a taken branch
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int BR_EXTRA    = 0,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    pipeline_hazard_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, BR_FLUSH} state_t;

    localparam logic [7:0] TMO_LIM = 8'(MEM_TIMEOUT);
    localparam logic [7:0] BR_LOAD = 8'(BR_EXTRA);

    state_t           state, state_nx;
    logic [7:0]       tmo_cnt, tmo_cnt_nx;
    logic [7:0]       br_cnt, br_cnt_nx;
    logic             mem_err, err_set;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             mem_wait_c, data_hz;
    logic             m1, m2, n1, n2;
    logic             freeze_front, freeze_back, flush_if_id, flush_id_ex, hazard;

    always_comb begin
        m1 = bus.src1_used & (bus.src1 == bus.exe_dest) & bus.exe_wb_en;
        m2 = bus.src2_used & (bus.src2 == bus.exe_dest) & bus.exe_wb_en;
        n1 = bus.src1_used & (bus.src1 == bus.mem_dest) & bus.mem_wb_en;
        n2 = bus.src2_used & (bus.src2 == bus.mem_dest) & bus.mem_wb_en;
        data_hz = bus.fwd_en ? (bus.exe_mem_r_en & (m1 | m2)) : (m1 | m2 | n1 | n2);
        mem_wait_c = bus.mem_req & ~bus.mem_ready & (state != BR_FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            tmo_cnt <= '0;
            br_cnt  <= '0;
            mem_err <= 1'b0;
        end else begin
            state   <= state_nx;
            tmo_cnt <= tmo_cnt_nx;
            br_cnt  <= br_cnt_nx;
            if (err_set) mem_err <= 1'b1;
        end
    end

    always_comb begin
        state_nx     = state;
        tmo_cnt_nx   = tmo_cnt;
        br_cnt_nx    = br_cnt;
        err_set      = 1'b0;
        freeze_front = 1'b0;
        freeze_back  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        hazard       = 1'b0;
        case (state)
            RUN: begin
                if (mem_wait_c) begin
                    freeze_front = 1'b1;
                    freeze_back  = 1'b1;
                    state_nx     = MEM_WAIT;
                    tmo_cnt_nx   = 8'd1;
                end else if (bus.branch_taken) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    if (BR_EXTRA > 0) begin
                        state_nx  = BR_FLUSH;
                        br_cnt_nx = BR_LOAD;
                    end
                end else if (data_hz) begin
                    hazard       = 1'b1;
                    freeze_front = 1'b1;
                    flush_id_ex  = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Branch and hazard are deliberately not looked at: EX is frozen and re-presents them.
                if (mem_wait_c) begin
                    freeze_front = 1'b1;
                    freeze_back  = 1'b1;
                    if (tmo_cnt == TMO_LIM) begin
                        err_set    = 1'b1;
                        state_nx   = RUN;
                        tmo_cnt_nx = '0;
                    end else begin
                        tmo_cnt_nx = tmo_cnt + 8'd1;
                    end
                end else begin
                    state_nx   = RUN;
                    tmo_cnt_nx = '0;
                end
            end
            BR_FLUSH: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                br_cnt_nx   = br_cnt - 8'd1;
                if (br_cnt == 8'd1) state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (freeze_front && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
            if (flush_id_ex && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.freeze_front = freeze_front;
    assign bus.freeze_back  = freeze_back;
    assign bus.flush_if_id  = flush_if_id;
    assign bus.flush_id_ex  = flush_id_ex;
    assign bus.hazard       = hazard;
    assign bus.mem_err      = mem_err;
    assign bus.stall_cnt    = stall_cnt;
    assign bus.flush_cnt    = flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
// A second instance with a short timeout shares the stimulus to exercise the memory-timeout path.
module tb_pipeline_hazard_ctrl;
    localparam int CNT_W = 5;
    localparam int BRX   = 2;
    localparam int TMO   = 6;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus_t ();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .BR_EXTRA(BRX), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .BR_EXTRA(BRX), .MEM_TIMEOUT(3)) dut_t (
        .clk(clk), .rst(rst), .bus(bus_t));

    assign bus_t.src1 = bus.src1;             assign bus_t.src2 = bus.src2;
    assign bus_t.src1_used = bus.src1_used;   assign bus_t.src2_used = bus.src2_used;
    assign bus_t.exe_dest = bus.exe_dest;     assign bus_t.exe_wb_en = bus.exe_wb_en;
    assign bus_t.exe_mem_r_en = bus.exe_mem_r_en;
    assign bus_t.mem_dest = bus.mem_dest;     assign bus_t.mem_wb_en = bus.mem_wb_en;
    assign bus_t.fwd_en = bus.fwd_en;         assign bus_t.branch_taken = bus.branch_taken;
    assign bus_t.mem_req = bus.mem_req;       assign bus_t.mem_ready = bus.mem_ready;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: cycles spent waiting, bubbles still owed, sticky error, counts.
    int m_wait, m_flush, m_err, m_stall, m_fcnt;
    bit e_ff, e_fb, e_fi, e_fe, e_hz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_flush = 0; m_err = 0; m_stall = 0; m_fcnt = 0;
    endtask

    task automatic model_comb();
        bit waiting, m1, m2, n1, n2, hz;
        waiting = (m_flush == 0) && bus.mem_req && !bus.mem_ready;
        m1 = bus.src1_used && bus.src1 == bus.exe_dest && bus.exe_wb_en;
        m2 = bus.src2_used && bus.src2 == bus.exe_dest && bus.exe_wb_en;
        n1 = bus.src1_used && bus.src1 == bus.mem_dest && bus.mem_wb_en;
        n2 = bus.src2_used && bus.src2 == bus.mem_dest && bus.mem_wb_en;
        hz = bus.fwd_en ? (bus.exe_mem_r_en && (m1 || m2)) : (m1 || m2 || n1 || n2);
        {e_ff, e_fb, e_fi, e_fe, e_hz} = '0;
        if (waiting) begin
            e_ff = 1; e_fb = 1;
        end else if (m_flush > 0) begin
            e_fi = 1; e_fe = 1;
        end else if (m_wait > 0) begin
        end else if (bus.branch_taken) begin
            e_fi = 1; e_fe = 1;
        end else if (hz) begin
            e_hz = 1; e_ff = 1; e_fe = 1;
        end
    endtask

    task automatic model_update();
        bit waiting;
        waiting = (m_flush == 0) && bus.mem_req && !bus.mem_ready;
        if (waiting) begin
            if (m_wait == 0) m_wait = 1;
            else if (m_wait == TMO) begin m_err = 1; m_wait = 0; end
            else m_wait++;
        end else if (m_flush > 0) m_flush--;
        else if (m_wait > 0) m_wait = 0;
        else if (bus.branch_taken) m_flush = BRX;
        m_stall = (m_stall + int'(e_ff) > MAXC) ? MAXC : m_stall + int'(e_ff);
        m_fcnt  = (m_fcnt + int'(e_fe) > MAXC) ? MAXC : m_fcnt + int'(e_fe);
    endtask

    task automatic check_outputs();
        model_comb();
        chk("freeze_front", bus.freeze_front, e_ff);
        chk("freeze_back", bus.freeze_back, e_fb);
        chk("flush_if_id", bus.flush_if_id, e_fi);
        chk("flush_id_ex", bus.flush_id_ex, e_fe);
        chk("hazard", bus.hazard, e_hz);
        chk("mem_err", bus.mem_err, m_err);
        chk("stall_cnt", bus.stall_cnt, m_stall);
        chk("flush_cnt", bus.flush_cnt, m_fcnt);
    endtask

    // Called just after a falling edge with inputs already set; returns at the next falling edge.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.src1 = 0; bus.src2 = 0; bus.src1_used = 0; bus.src2_used = 0;
        bus.exe_dest = 0; bus.exe_wb_en = 0; bus.exe_mem_r_en = 0;
        bus.mem_dest = 0; bus.mem_wb_en = 0; bus.fwd_en = 0;
        bus.branch_taken = 0; bus.mem_req = 0; bus.mem_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        #1;
        model_reset();
        check_outputs();
        chk("rst_t_err", bus_t.mem_err, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        set_idle();
        @(negedge clk);
        do_reset();
        cycle();

        // Load-use with forwarding
        bus.fwd_en = 1; bus.exe_mem_r_en = 1; bus.exe_wb_en = 1; bus.exe_dest = 3;
        bus.src1 = 3; bus.src1_used = 1;
        #1 chk("lu_hazard", bus.hazard, 1);
        cycle();
        set_idle();
        #1;
        chk("lu_stall_cnt", bus.stall_cnt, 1);
        chk("lu_flush_cnt", bus.flush_cnt, 1);
        chk("lu_hazard_gone", bus.hazard, 0);
        cycle();

        // MEM-stage dependency: hazard only without forwarding
        bus.mem_wb_en = 1; bus.mem_dest = 5; bus.src2 = 5; bus.src2_used = 1;
        #1 chk("nofwd_hazard", bus.hazard, 1);
        cycle();
        bus.fwd_en = 1;
        #1 chk("fwd_no_hazard", bus.hazard, 0);
        cycle();

        // Memory wait with a concurrent branch
        do_reset();
        bus.mem_req = 1; bus.mem_ready = 0; bus.branch_taken = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("mw_freeze_back", bus.freeze_back, 1);
            chk("mw_no_flush", bus.flush_if_id, 0);
            cycle();
        end
        bus.mem_ready = 1;
        #1;
        chk("mw_release", bus.freeze_front, 0);
        chk("mw_release_noflush", bus.flush_id_ex, 0);
        cycle();
        bus.mem_req = 0; bus.mem_ready = 0;
        #1 chk("mw_branch_after", bus.flush_if_id, 1);
        cycle();
        bus.branch_taken = 0;
        cycle(); cycle(); cycle();

        // Timeout on the short-timeout instance
        do_reset();
        bus.mem_req = 1; bus.mem_ready = 0;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk($sformatf("tmo_err_%0d", k), bus_t.mem_err, (k == 4) ? 1 : 0);
        end
        #1 chk("tmo_refreeze", bus_t.freeze_back, 1);
        bus.mem_req = 0;
        cycle(); cycle();
        chk("tmo_sticky", bus_t.mem_err, 1);

        // Branch with BR_EXTRA=2, then reset during the last bubble
        do_reset();
        bus.branch_taken = 1;
        cycle();
        bus.branch_taken = 0;
        #1 chk("br_cycle1", bus.flush_if_id, 1);
        cycle();
        #1 chk("br_cycle2", bus.flush_id_ex, 1);
        cycle();
        #1 chk("br_done", bus.flush_id_ex, 0);
        cycle();
        bus.branch_taken = 1;
        cycle();
        bus.branch_taken = 0;
        cycle();
        #1 chk("br2_cycle2", bus.flush_if_id, 1);
        rst = 1'b1;
        #1;
        chk("br_rst_fi", bus.flush_if_id, 0);
        chk("br_rst_fe", bus.flush_id_ex, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle();

        // Random traffic; small register space forces frequent matches
        for (int i = 0; i < 1500; i++) begin
            bus.src1 = 4'($urandom_range(0, 3));
            bus.src2 = 4'($urandom_range(0, 3));
            bus.src1_used = 1'($urandom);
            bus.src2_used = 1'($urandom);
            bus.exe_dest = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            bus.exe_wb_en = 1'($urandom);
            bus.exe_mem_r_en = 1'($urandom);
            bus.mem_dest = 4'($urandom_range(0, 3));
            bus.mem_wb_en = 1'($urandom);
            bus.fwd_en = 1'($urandom);
            bus.branch_taken = ($urandom_range(0, 7) == 0);
            bus.mem_req = ($urandom_range(0, 3) == 0);
            bus.mem_ready = ($urandom_range(0, 2) == 0);
            if (i == 750) begin
                do_reset();
            end else begin
                cycle();
            end
        end
        set_idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
